// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N_REQ console requesters and one UART transmit port.
// master = arbiter side, slave = requesters/downstream side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ*DATA_WIDTH-1:0] req_bits;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_WIDTH-1:0]       out_bits;

    modport master (
        input  req_valid, req_bits, out_ready,
        output req_ready, out_valid, out_bits
    );

    modport slave (
        output req_valid, req_bits, out_ready,
        input  req_ready, out_valid, out_bits
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-granular arbiter sharing one UART byte stream among N_REQ requesters.
// Optional: define UART_ARB_TAG_EN to emit the granted requester's ASCII id before its bytes.
module uart_tx_arbiter #(
    parameter int                    N_REQ         = 4,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    MAX_BURST     = 64,
    parameter logic [DATA_WIDTH-1:0] EOL_BYTE      = 8'h0A,
    parameter int                    STALL_TIMEOUT = 32,
    localparam int                   GW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_tx_arbiter_if.master    bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, TAG = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1} state_t;
`endif

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      stall_cnt_q, stall_cnt_d;

    logic [DATA_WIDTH-1:0] req_byte [N_REQ];
    logic [GW-1:0]         rot_idx  [N_REQ];
    logic [N_REQ-1:0]      rot_valid;
    logic                  pick_valid;
    logic [GW-1:0]         pick_idx;
    logic                  g_valid;
    logic [DATA_WIDTH-1:0] g_byte;
    logic                  release_now;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_bits;
    logic [N_REQ-1:0]      req_ready;

    // rot_idx[k] is the requester k places after rr_ptr, wrapped modulo N_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [GW:0] sum;
            assign req_byte[gi]  = bus.req_bits[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sum           = {1'b0, rr_ptr_q} + (GW+1)'(gi);
            assign rot_idx[gi]   = GW'((sum >= (GW+1)'(N_REQ)) ? sum - (GW+1)'(N_REQ) : sum);
            assign rot_valid[gi] = bus.req_valid[rot_idx[gi]];
        end
    endgenerate

    // Walk from the far end so the nearest asserted requester to rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                pick_valid = 1'b1;
                pick_idx   = rot_idx[k];
            end
        end
    end

    assign g_valid = bus.req_valid[grant_q];
    assign g_byte  = req_byte[grant_q];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        byte_cnt_d  = byte_cnt_q;
        stall_cnt_d = stall_cnt_q;
        out_valid   = 1'b0;
        out_bits    = '0;
        req_ready   = '0;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_idx;
                    byte_cnt_d  = '0;
                    stall_cnt_d = '0;
`ifdef UART_ARB_TAG_EN
                    state_d     = TAG;
`else
                    state_d     = STREAM;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                out_valid = 1'b1;
                out_bits  = (int'(grant_q) < 10) ? DATA_WIDTH'(int'(grant_q) + 'h30)
                                                 : DATA_WIDTH'(int'(grant_q) + 'h41 - 10);
                if (bus.out_ready) begin
                    state_d = STREAM;
                end
            end
`endif
            STREAM: begin
                out_valid          = g_valid;
                out_bits           = g_byte;
                req_ready[grant_q] = bus.out_ready;
                if (g_valid && bus.out_ready) begin
                    byte_cnt_d  = byte_cnt_q + 8'd1;
                    stall_cnt_d = '0;
                    if (g_byte == EOL_BYTE || byte_cnt_q == 8'(MAX_BURST - 1)) begin
                        release_now = 1'b1;
                    end
                end else if (!g_valid) begin
                    // Backpressure (valid high, ready low) deliberately leaves the stall count alone.
                    if (stall_cnt_q == 8'(STALL_TIMEOUT - 1)) begin
                        release_now = 1'b1;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 8'd1;
                    end
                end
                if (release_now) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            byte_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            byte_cnt_q  <= byte_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_bits  = out_bits;
    assign bus.req_ready = req_ready;
    assign grant_id      = grant_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed line/burst/stall/reset scenarios
// plus randomized traffic checked against a queue-based reference model.
module tb_uart_tx_arbiter;
    localparam int         N    = 4;
    localparam int         DW   = 8;
    localparam int         MAXB = 64;
    localparam int         STO  = 32;
    localparam int         GW   = 2;
    localparam logic [7:0] EOL  = 8'h0A;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [GW-1:0] grant_id;
    logic          busy;

    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus();

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .EOL_BYTE(EOL), .STALL_TIMEOUT(STO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .grant_id(grant_id),
        .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]   byte_q [N][$];
    logic [N-1:0] en_mask = '1;
    logic         rdy = 1'b0;

    logic         o_valid, o_busy, o_xfer;
    logic [7:0]   o_bits;
    logic [GW-1:0] o_gid;
    logic [N-1:0] o_rdy;

    // Drive from the per-requester queues, sample at negedge, pop what was handshaken.
    task automatic cycle();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]        = en_mask[i] && (byte_q[i].size() > 0);
            bus.req_bits[i*DW +: DW] = (byte_q[i].size() > 0) ? byte_q[i][0] : 8'h00;
        end
        bus.out_ready = rdy;
        @(negedge clock);
        o_valid = bus.out_valid;
        o_bits  = bus.out_bits;
        o_gid   = grant_id;
        o_busy  = busy;
        o_rdy   = bus.req_ready;
        o_xfer  = bus.out_valid && rdy;
        for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                $display("xfer req=%0d byte=%02h", i, byte_q[i][0]);
                void'(byte_q[i].pop_front());
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rdy   = 1'b0;
        en_mask = '1;
        for (int i = 0; i < N; i++) byte_q[i].delete();
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic push_str(input int r, input string s);
        for (int k = 0; k < s.len(); k++) byte_q[r].push_back(s[k]);
        byte_q[r].push_back(EOL);
    endtask

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 5) == 0) return EOL;
        return 8'($urandom_range(32, 126));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        push_str(1, "q");
        cycle();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", o_valid); end
        total++; if (o_bits !== 8'h00) begin bad++; $display("FAIL rst_bits got=%02h want=00", o_bits); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", o_busy); end
        total++; if (o_gid !== '0) begin bad++; $display("FAIL rst_gid got=%0d want=0", o_gid); end
        total++; if (o_rdy !== '0) begin bad++; $display("FAIL rst_ready got=%b want=0", o_rdy); end
        do_reset();
    endtask

    task automatic test_single_line();
        logic [7:0] msg [3];
        msg[0] = 8'h68; msg[1] = 8'h69; msg[2] = 8'h0A;
        do_reset();
        rdy = 1'b1;
        push_str(1, "hi");
        cycle();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL line_arb got=%b want=0", o_valid); end
        for (int k = 0; k < 3; k++) begin
            cycle();
            total++;
            if (o_valid !== 1'b1 || o_bits !== msg[k] || o_gid !== 2'd1 || o_rdy !== 4'b0010 || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL line_byte%0d got v=%b b=%02h g=%0d r=%b busy=%b want v=1 b=%02h g=1 r=0010 busy=1",
                         k, o_valid, o_bits, o_gid, o_rdy, o_busy, msg[k]);
            end
        end
        cycle();
        total++; if (o_busy !== 1'b0 || o_gid !== 2'd1) begin bad++; $display("FAIL line_release got busy=%b g=%0d want busy=0 g=1", o_busy, o_gid); end
    endtask

    task automatic test_two_reqs();
        int         eg [8];
        logic [7:0] eb [8];
        eg = '{-1, 0, 0, 0, -1, 2, 2, 2};
        eb = '{8'h00, 8'h61, 8'h62, 8'h0A, 8'h00, 8'h61, 8'h62, 8'h0A};
        do_reset();
        rdy = 1'b1;
        push_str(0, "ab");
        push_str(2, "ab");
        for (int c = 0; c < 8; c++) begin
            cycle();
            total++;
            if (eg[c] < 0) begin
                if (o_valid !== 1'b0) begin bad++; $display("FAIL rr_bubble%0d got v=%b want v=0", c, o_valid); end
            end else if (o_valid !== 1'b1 || int'(o_gid) != eg[c] || o_bits !== eb[c]) begin
                bad++;
                $display("FAIL rr_cycle%0d got v=%b g=%0d b=%02h want v=1 g=%0d b=%02h", c, o_valid, o_gid, o_bits, eg[c], eb[c]);
            end
        end
        push_str(0, "z");
        push_str(3, "z");
        cycle();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rr_rearb got v=%b want v=0", o_valid); end
        cycle();
        total++; if (o_gid !== 2'd3 || o_bits !== 8'h7A) begin bad++; $display("FAIL rr_ptr got g=%0d b=%02h want g=3 b=7a", o_gid, o_bits); end
    endtask

    task automatic test_burst();
        int         lg_g [$];
        logic [7:0] lg_b [$];
        int         lg_c [$];
        int         eg, ec;
        logic [7:0] eb;
        do_reset();
        rdy = 1'b1;
        for (int k = 0; k < 70; k++) byte_q[0].push_back(8'(8'h41 + k % 26));
        push_str(1, "q");
        for (int c = 1; c <= 90; c++) begin
            cycle();
            if (o_xfer) begin
                lg_g.push_back(int'(o_gid)); lg_b.push_back(o_bits); lg_c.push_back(c);
            end
        end
        total++; if (lg_g.size() != 72) begin bad++; $display("FAIL burst_count got=%0d want=72", lg_g.size()); end
        for (int t = 0; t < 72 && t < lg_g.size(); t++) begin
            if (t < 64) begin eg = 0; eb = 8'(8'h41 + t % 26); ec = 2 + t; end
            else if (t < 66) begin eg = 1; eb = (t == 64) ? 8'h71 : EOL; ec = 67 + t - 64; end
            else begin eg = 0; eb = 8'(8'h41 + (t - 2) % 26); ec = 70 + t - 66; end
            total++;
            if (lg_g[t] != eg || lg_b[t] !== eb || lg_c[t] != ec) begin
                bad++;
                $display("FAIL burst_xfer%0d got g=%0d b=%02h cyc=%0d want g=%0d b=%02h cyc=%0d",
                         t, lg_g[t], lg_b[t], lg_c[t], eg, eb, ec);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        rdy = 1'b1;
        byte_q[0].push_back(8'h61);
        push_str(3, "w");
        cycle();
        cycle();
        total++; if (!o_xfer || o_gid !== 2'd0 || o_bits !== 8'h61) begin bad++; $display("FAIL stall_first got x=%b g=%0d b=%02h want x=1 g=0 b=61", o_xfer, o_gid, o_bits); end
        for (int c = 0; c < STO; c++) begin
            cycle();
            total++;
            if (o_busy !== 1'b1 || o_gid !== 2'd0 || o_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d got busy=%b g=%0d v=%b want busy=1 g=0 v=0", c, o_busy, o_gid, o_valid);
            end
        end
        cycle();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL stall_release got busy=%b want 0", o_busy); end
        cycle();
        total++; if (!o_xfer || o_gid !== 2'd3 || o_bits !== 8'h77) begin bad++; $display("FAIL stall_next got x=%b g=%0d b=%02h want x=1 g=3 b=77", o_xfer, o_gid, o_bits); end

        do_reset();
        rdy = 1'b0;
        byte_q[0].push_back(8'h61);
        push_str(3, "w");
        cycle();
        for (int c = 0; c < 100; c++) begin
            cycle();
            total++;
            if (o_busy !== 1'b1 || o_gid !== 2'd0 || o_valid !== 1'b1 || o_rdy !== '0) begin
                bad++;
                $display("FAIL bp_hold%0d got busy=%b g=%0d v=%b r=%b want busy=1 g=0 v=1 r=0000", c, o_busy, o_gid, o_valid, o_rdy);
            end
        end
        rdy = 1'b1;
        cycle();
        total++; if (!o_xfer || o_gid !== 2'd0 || o_rdy !== 4'b0001) begin bad++; $display("FAIL bp_resume got x=%b g=%0d r=%b want x=1 g=0 r=0001", o_xfer, o_gid, o_rdy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rdy = 1'b1;
        push_str(0, "x");
        push_str(2, "abcdef");
        for (int c = 0; c < 4; c++) cycle();
        cycle();
        total++; if (o_gid !== 2'd2 || o_bits !== 8'h61) begin bad++; $display("FAIL mid_pre got g=%0d b=%02h want g=2 b=61", o_gid, o_bits); end
        cycle();
        reset = 1'b1;
        rdy   = 1'b0;
        cycle();
        reset = 1'b0;
        rdy   = 1'b1;
        push_str(0, "y");
        cycle();
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_gid !== 2'd0 || o_rdy !== '0) begin
            bad++;
            $display("FAIL mid_abort got v=%b busy=%b g=%0d r=%b want v=0 busy=0 g=0 r=0000", o_valid, o_busy, o_gid, o_rdy);
        end
        cycle();
        total++; if (!o_xfer || o_gid !== 2'd0 || o_bits !== 8'h79) begin bad++; $display("FAIL mid_restart got x=%b g=%0d b=%02h want x=1 g=0 b=79", o_xfer, o_gid, o_bits); end
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        do_reset();
        rdy = 1'b0;
        push_str(2, "x");
        cycle();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL tag_arb got v=%b want 0", o_valid); end
        for (int c = 0; c < 3; c++) begin
            cycle();
            total++;
            if (o_valid !== 1'b1 || o_bits !== 8'h32 || o_rdy !== '0 || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL tag_hold%0d got v=%b b=%02h r=%b busy=%b want v=1 b=32 r=0000 busy=1", c, o_valid, o_bits, o_rdy, o_busy);
            end
        end
        rdy = 1'b1;
        cycle();
        total++; if (!o_xfer || o_bits !== 8'h32 || o_rdy !== '0) begin bad++; $display("FAIL tag_send got x=%b b=%02h r=%b want x=1 b=32 r=0000", o_xfer, o_bits, o_rdy); end
        cycle();
        total++; if (!o_xfer || o_bits !== 8'h78 || o_rdy !== 4'b0100) begin bad++; $display("FAIL tag_x got x=%b b=%02h r=%b want x=1 b=78 r=0100", o_xfer, o_bits, o_rdy); end
        cycle();
        total++; if (!o_xfer || o_bits !== EOL) begin bad++; $display("FAIL tag_eol got x=%b b=%02h want x=1 b=0a", o_xfer, o_bits); end
    endtask
`else
    // Model: owner is -1 when nobody holds the stream; lines end on EOL, MAXB bytes, or STO idle cycles.
    task automatic test_random();
        int           owner    = -1;
        int           ptr      = 0;
        int           run      = 0;
        int           idle_run = 0;
        bit           mute [N];
        logic [N-1:0] vld;
        logic [7:0]   head [N];
        logic [N-1:0] exp_rdy;
        logic         exp_v;
        logic         rel;
        do_reset();
        for (int i = 0; i < N; i++) mute[i] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0) mute[i] = !mute[i];
                while (byte_q[i].size() < 2) byte_q[i].push_back(rand_byte());
                en_mask[i] = !mute[i] && ($urandom_range(0, 9) < 8);
                vld[i]     = en_mask[i];
                head[i]    = byte_q[i][0];
            end
            rdy     = ($urandom_range(0, 3) != 0);
            exp_v   = (owner >= 0) && vld[owner];
            exp_rdy = '0;
            if (owner >= 0 && rdy) exp_rdy[owner] = 1'b1;
            cycle();
            total++; if (o_valid !== exp_v) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, o_valid, exp_v); end
            total++; if (o_busy !== (owner >= 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, o_busy, owner >= 0); end
            total++; if (o_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, o_rdy, exp_rdy); end
            if (owner >= 0) begin
                total++; if (int'(o_gid) != owner) begin bad++; $display("FAIL rnd_gid c=%0d got=%0d want=%0d", c, o_gid, owner); end
            end
            if (exp_v) begin
                total++; if (o_bits !== head[owner]) begin bad++; $display("FAIL rnd_bits c=%0d got=%02h want=%02h", c, o_bits, head[owner]); end
            end else begin
                total++; if (owner < 0 && o_bits !== 8'h00) begin bad++; $display("FAIL rnd_idlebits c=%0d got=%02h want=00", c, o_bits); end
            end
            rel = 1'b0;
            if (owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (vld[(ptr + k) % N]) begin
                        owner = (ptr + k) % N; run = 0; idle_run = 0;
                        break;
                    end
                end
            end else if (exp_v && rdy) begin
                run++;
                idle_run = 0;
                rel = (head[owner] == EOL) || (run == MAXB);
            end else if (!vld[owner]) begin
                idle_run++;
                rel = (idle_run == STO);
            end
            if (rel) begin
                ptr   = (owner + 1) % N;
                owner = -1;
            end
        end
        en_mask = '1;
    endtask
`endif

    initial begin
        test_reset();
`ifdef UART_ARB_TAG_EN
        test_tag();
`else
        test_single_line();
        test_two_reqs();
        test_burst();
        test_stall();
        test_reset_mid();
        test_random();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
